// File: rtl/ftdi_sync_rx_stream.sv
// ftdi_sync_rx_stream
//   Reads bytes from an FTDI FT245-style synchronous FIFO interface, packs
//   them into BYTES_PER_WORD-byte words (first byte in lane 0) and buffers
//   them in a first-word fall-through FIFO with a valid/ready output stream.
//
// Ports
//   clk_i       60 MHz FTDI clock, the only clock
//   rst_i       asynchronous active-high reset
//   rxf_n_i     FTDI RXF#, low when the chip holds data
//   data_i      FTDI data bus
//   rd_n_o      FTDI RD#, decoded from the state register
//   oe_n_o      FTDI OE#, decoded from the state register
//   enable_i    permits new read bursts
//   flush_i     one-cycle pulse, pushes a partially packed word
//   m_data_o    output word, first captured byte in the LSBs
//   m_keep_o    per-byte valid mask of m_data_o
//   m_valid_o   output word available (FIFO not empty)
//   m_ready_i   consumer accepts the output word
//   busy_o      FSM not in IDLE
//   rx_count_o  total captured bytes, wraps modulo 2^32
module ftdi_sync_rx_stream #(
    parameter int BYTES_PER_WORD = 1,
    parameter int FIFO_DEPTH     = 16,
    parameter int MAX_BURST      = 512,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rxf_n_i,
    input  logic [7:0]                    data_i,
    output logic                          rd_n_o,
    output logic                          oe_n_o,
    input  logic                          enable_i,
    input  logic                          flush_i,
    output logic [8*BYTES_PER_WORD-1:0]   m_data_o,
    output logic [BYTES_PER_WORD-1:0]     m_keep_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic                          busy_o,
    output logic [31:0]                   rx_count_o
);

    localparam int W  = 8 * BYTES_PER_WORD;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    localparam logic [AW:0]   TURN_MAX  = (AW+1)'(FIFO_DEPTH - 3);
    localparam logic [AW:0]   EXIT_MIN  = (AW+1)'(FIFO_DEPTH - 2);
    localparam logic [LW-1:0] LAST_LANE = LW'(BYTES_PER_WORD - 1);
    localparam logic [31:0]   BURST_LIM = 32'(MAX_BURST);
    localparam logic [31:0]   GAP_LOAD  = 32'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_READ,
        S_RELEASE,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   burst_q, burst_d;
    logic [31:0]   gap_q,   gap_d;
    logic          lim_q,   lim_d;
    logic [LW-1:0] lane_q,  lane_d;
    logic [W-1:0]  word_q,  word_d;
    logic [31:0]   rx_count_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   fill_q,   fill_d;

    logic [BYTES_PER_WORD+W-1:0] mem [FIFO_DEPTH];

    logic                      cap;
    logic                      limit_hit;
    logic [W-1:0]              merged;
    int unsigned               filled;
    logic                      push;
    logic                      pop;
    logic [BYTES_PER_WORD-1:0] push_keep;

    // A byte is taken whenever RD# is low and the chip still flags data,
    // including the edge on which READ is left.
    assign cap       = (state_q == S_READ) && !rxf_n_i;
    assign limit_hit = (MAX_BURST != 0) && ((burst_q + 32'(cap)) == BURST_LIM);

    assign rd_n_o = (state_q != S_READ);
    assign oe_n_o = (state_q == S_IDLE) || (state_q == S_GAP);
    assign busy_o = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        gap_d   = gap_q;
        lim_d   = lim_q;
        case (state_q)
            S_IDLE: begin
                if (!rxf_n_i && enable_i && (fill_q <= TURN_MAX)) begin
                    state_d = S_TURN;
                    burst_d = '0;
                end
            end
            S_TURN: state_d = S_READ;
            S_READ: begin
                if (cap) begin
                    burst_d = burst_q + 32'd1;
                end
                // Exit at fill >= DEPTH-2 leaves room for the capture on this
                // edge plus one flush of a partial word.
                if (rxf_n_i || !enable_i || (fill_q >= EXIT_MIN) || limit_hit) begin
                    state_d = S_RELEASE;
                    lim_d   = limit_hit;
                end
            end
            S_RELEASE: begin
                if (lim_q && (GAP_CYCLES > 0)) begin
                    state_d = S_GAP;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Packer: the captured byte is merged first, so a flush on the same edge
    // sees it; a word completed by that byte is pushed once as a full word.
    always_comb begin
        merged = word_q;
        if (cap) begin
            merged[{lane_q, 3'b000} +: 8] = data_i;
        end
        filled    = 32'(lane_q) + 32'(cap);
        push      = 1'b0;
        push_keep = '0;
        lane_d    = lane_q;
        word_d    = word_q;
        if (cap && (lane_q == LAST_LANE)) begin
            push      = 1'b1;
            push_keep = '1;
            lane_d    = '0;
            word_d    = '0;
        end else if (flush_i && (filled != 0)) begin
            push = 1'b1;
            for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
                push_keep[i] = (i < filled);
            end
            lane_d = '0;
            word_d = '0;
        end else if (cap) begin
            lane_d = lane_q + LW'(1);
            word_d = merged;
        end
    end

    assign m_valid_o = (fill_q != '0);
    assign pop       = m_valid_o && m_ready_i;

    always_comb begin
        fill_d = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + (AW+1)'(1);
        end else if (pop && !push) begin
            fill_d = fill_q - (AW+1)'(1);
        end
    end

    assign {m_keep_o, m_data_o} = m_valid_o ? mem[rd_ptr_q] : '0;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= {push_keep, merged};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            burst_q    <= '0;
            gap_q      <= '0;
            lim_q      <= 1'b0;
            lane_q     <= '0;
            word_q     <= '0;
            rx_count_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            gap_q   <= gap_d;
            lim_q   <= lim_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            fill_q  <= fill_d;
            if (cap) begin
                rx_count_q <= rx_count_q + 32'd1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign rx_count_o = rx_count_q;

endmodule

// File: tb/tb_ftdi_sync_rx_stream.sv
// tb_ftdi_sync_rx_stream
//   Directed bench. Instance A uses the default parameters; instance B packs
//   4 bytes per word into an 8-deep FIFO with 4-byte bursts and a 2-cycle gap.
//   Each instance is fed by a small FTDI source model (byte queue) and its
//   output stream is collected into a queue for comparison.
module tb_ftdi_sync_rx_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A
    logic        a_rst, a_rxf_n, a_rd_n, a_oe_n, a_en, a_flush;
    logic [7:0]  a_data, a_mdata;
    logic [0:0]  a_keep;
    logic        a_valid, a_ready, a_busy;
    logic [31:0] a_count;

    // instance B
    logic        b_rst, b_rxf_n, b_rd_n, b_oe_n, b_en, b_flush;
    logic [7:0]  b_data;
    logic [31:0] b_mdata;
    logic [3:0]  b_keep;
    logic        b_valid, b_ready, b_busy;
    logic [31:0] b_count;

    ftdi_sync_rx_stream dut_a (
        .clk_i(clk), .rst_i(a_rst), .rxf_n_i(a_rxf_n), .data_i(a_data),
        .rd_n_o(a_rd_n), .oe_n_o(a_oe_n), .enable_i(a_en), .flush_i(a_flush),
        .m_data_o(a_mdata), .m_keep_o(a_keep), .m_valid_o(a_valid),
        .m_ready_i(a_ready), .busy_o(a_busy), .rx_count_o(a_count)
    );

    ftdi_sync_rx_stream #(
        .BYTES_PER_WORD(4),
        .FIFO_DEPTH(8),
        .MAX_BURST(4),
        .GAP_CYCLES(2)
    ) dut_b (
        .clk_i(clk), .rst_i(b_rst), .rxf_n_i(b_rxf_n), .data_i(b_data),
        .rd_n_o(b_rd_n), .oe_n_o(b_oe_n), .enable_i(b_en), .flush_i(b_flush),
        .m_data_o(b_mdata), .m_keep_o(b_keep), .m_valid_o(b_valid),
        .m_ready_i(b_ready), .busy_o(b_busy), .rx_count_o(b_count)
    );

    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [8:0]  oa[$];
    logic [35:0] ob[$];
    logic        a_hold = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        a_rxf_n = a_hold || (qa.size() == 0);
        a_data  = (qa.size() != 0) ? qa[0] : 8'h00;
        b_rxf_n = (qb.size() == 0);
        b_data  = (qb.size() != 0) ? qb[0] : 8'h00;
    endtask

    // One clock: sample handshakes before the edge, update the models #1 after.
    task automatic tick();
        logic        take_a, take_b, acc_a, acc_b;
        logic [8:0]  wa;
        logic [35:0] wb;
        take_a = !a_rd_n && !a_rxf_n;
        take_b = !b_rd_n && !b_rxf_n;
        acc_a  = a_valid && a_ready;
        acc_b  = b_valid && b_ready;
        wa     = {a_keep, a_mdata};
        wb     = {b_keep, b_mdata};
        @(posedge clk);
        #1;
        if (take_a) void'(qa.pop_front());
        if (take_b) void'(qb.pop_front());
        if (acc_a) oa.push_back(wa);
        if (acc_b) ob.push_back(wb);
        drive_src();
    endtask

    function automatic logic [8:0] pop_a();
        if (oa.size() == 0) return '1;
        return oa.pop_front();
    endfunction

    function automatic logic [35:0] pop_b();
        if (ob.size() == 0) return '1;
        return ob.pop_front();
    endfunction

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_en = 1'b1; b_en = 1'b1;
        a_flush = 1'b0; b_flush = 1'b0;
        a_ready = 1'b1; b_ready = 1'b1;
        drive_src();
        #2;
        check_eq("rst_a_rd_n", a_rd_n, 1);
        check_eq("rst_a_oe_n", a_oe_n, 1);
        check_eq("rst_a_valid", a_valid, 0);
        check_eq("rst_a_busy", a_busy, 0);
        check_eq("rst_a_count", a_count, 0);
        check_eq("rst_a_data", a_mdata, 0);
        check_eq("rst_a_keep", a_keep, 0);
        check_eq("rst_b_keep", b_keep, 0);
        check_eq("rst_b_data", b_mdata, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0;

        // 5 bytes, free-flowing output
        for (int i = 1; i <= 5; i++) qa.push_back(8'(i * 8'h11));
        drive_src();
        tick();
        check_eq("t1_turn_oe", a_oe_n, 0);
        check_eq("t1_turn_rd", a_rd_n, 1);
        check_eq("t1_turn_busy", a_busy, 1);
        tick();
        check_eq("t1_read_rd", a_rd_n, 0);
        repeat (5) tick();
        check_eq("t1_count", a_count, 5);
        check_eq("t1_still_read", a_rd_n, 0);
        tick();
        check_eq("t1_release_rd", a_rd_n, 1);
        check_eq("t1_release_oe", a_oe_n, 0);
        tick();
        check_eq("t1_idle_oe", a_oe_n, 1);
        check_eq("t1_idle_busy", a_busy, 0);
        repeat (3) tick();
        check_eq("t1_nwords", oa.size(), 5);
        for (int i = 1; i <= 5; i++) check_eq("t1_word", pop_a(), {1'b1, 8'(i * 8'h11)});

        // RXF# high for one cycle mid-burst
        for (int i = 0; i < 6; i++) qa.push_back(8'(8'hA0 + i));
        drive_src();
        repeat (4) tick();
        a_hold = 1'b1;
        drive_src();
        tick();
        a_hold = 1'b0;
        drive_src();
        check_eq("t2_release_rd", a_rd_n, 1);
        check_eq("t2_release_oe", a_oe_n, 0);
        tick();
        check_eq("t2_idle_busy", a_busy, 0);
        tick();
        check_eq("t2_turn_oe", a_oe_n, 0);
        repeat (10) tick();
        check_eq("t2_count", a_count, 11);
        check_eq("t2_nwords", oa.size(), 6);
        for (int i = 0; i < 6; i++) check_eq("t2_word", pop_a(), {1'b1, 8'(8'hA0 + i)});

        // asynchronous reset mid-READ with data buffered
        a_ready = 1'b0;
        for (int i = 0; i < 8; i++) qa.push_back(8'(8'hB0 + i));
        drive_src();
        repeat (4) tick();
        check_eq("t3_pre_valid", a_valid, 1);
        #2 a_rst = 1'b1;
        #1;
        check_eq("t3_rst_rd", a_rd_n, 1);
        check_eq("t3_rst_oe", a_oe_n, 1);
        check_eq("t3_rst_valid", a_valid, 0);
        check_eq("t3_rst_count", a_count, 0);
        check_eq("t3_rst_busy", a_busy, 0);
        #1 a_rst = 1'b0;
        tick();
        check_eq("t3_first_turn", a_oe_n, 0);
        a_ready = 1'b1;
        repeat (12) tick();
        check_eq("t3_count", a_count, 6);
        check_eq("t3_nwords", oa.size(), 6);
        for (int i = 2; i < 8; i++) check_eq("t3_word", pop_a(), {1'b1, 8'(8'hB0 + i)});

        // B: burst limit, gap, flush of a partial word
        for (int i = 1; i <= 6; i++) qb.push_back(8'(i));
        drive_src();
        tick();
        tick();
        check_eq("t4_read_rd", b_rd_n, 0);
        repeat (4) tick();
        check_eq("t4_limit_rd", b_rd_n, 1);
        check_eq("t4_limit_oe", b_oe_n, 0);
        check_eq("t4_limit_count", b_count, 4);
        tick();
        check_eq("t4_gap1_oe", b_oe_n, 1);
        check_eq("t4_gap1_busy", b_busy, 1);
        tick();
        check_eq("t4_gap2_oe", b_oe_n, 1);
        check_eq("t4_gap2_busy", b_busy, 1);
        tick();
        check_eq("t4_idle_busy", b_busy, 0);
        tick();
        check_eq("t4_turn_oe", b_oe_n, 0);
        repeat (5) tick();
        check_eq("t4_count", b_count, 6);
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        repeat (2) tick();
        check_eq("t4_nwords", ob.size(), 2);
        check_eq("t4_word0", pop_b(), {4'hF, 32'h04030201});
        check_eq("t4_word1", pop_b(), {4'h3, 32'h00000605});
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        repeat (2) tick();
        check_eq("t4_empty_flush", ob.size(), 0);

        // B: back-pressure fills the FIFO, reading stalls, then drains
        b_ready = 1'b0;
        for (int i = 0; i < 32; i++) qb.push_back(8'(8'h40 + i));
        drive_src();
        repeat (80) tick();
        check_eq("t5_stall_count", b_count, 30);
        check_eq("t5_stall_rd", b_rd_n, 1);
        check_eq("t5_stall_busy", b_busy, 0);
        check_eq("t5_stall_valid", b_valid, 1);
        b_ready = 1'b1;
        repeat (60) tick();
        check_eq("t5_count", b_count, 38);
        check_eq("t5_nwords", ob.size(), 8);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b0;
            b0 = 8'(8'h40 + 4 * i);
            check_eq("t5_word", pop_b(), {4'hF, b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ftdi_sync_rx_stream.md
FTDI_SYNC_RX_STREAM -- requirements
Module: ftdi_sync_rx_stream

Interface
REQ-001 SHALL have parameter BYTES_PER_WORD, default 1, meaning bytes packed per output word; legal values 1, 2, 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning output buffer depth in words; power of 2, >=8.
REQ-003 SHALL have parameter MAX_BURST, default 512, meaning max bytes per read burst; 0 means unlimited.
REQ-004 SHALL have parameter GAP_CYCLES, default 2, meaning idle cycles forced after a burst-limit release.
REQ-005 SHALL have port clk_i  in  1  60MHz FTDI clock; the block's only clock.
REQ-006 SHALL have port rst_i  in  1  reset; asynchronous, active-high.
REQ-007 SHALL have port rxf_n_i  in  1  FTDI RXF#, low = data available.
REQ-008 SHALL have port data_i  in  8  FTDI data bus.
REQ-009 SHALL have port rd_n_o  out  1  FTDI RD#, registered.
REQ-010 SHALL have port oe_n_o  out  1  FTDI OE#, registered.
REQ-011 SHALL have port enable_i  in  1  permits new bursts.
REQ-012 SHALL have port flush_i  in  1  one-cycle pulse; pushes a partial word.
REQ-013 SHALL have port m_data_o  out  8*BYTES_PER_WORD  output word, first byte in LSBs.
REQ-014 SHALL have port m_keep_o  out  BYTES_PER_WORD  per-byte valid mask.
REQ-015 SHALL have port m_valid_o / m_ready_i  out/in  1  output stream handshake.
REQ-016 SHALL have port busy_o  out  1  high when FSM is not in IDLE.
REQ-017 SHALL have port rx_count_o  out  32  total bytes captured; wraps modulo 2^32.

Function
REQ-018 FSM states SHALL be IDLE, TURN, READ, RELEASE and GAP; rd_n_o and oe_n_o SHALL be decoded from the state register: IDLE 1/1, TURN 1/0, READ 0/0, RELEASE 1/0, GAP 1/1.
REQ-019 IDLE SHALL go to TURN when rxf_n_i==0, enable_i==1 and the FIFO word fill is <= FIFO_DEPTH-3.
REQ-020 TURN SHALL go to READ unconditionally after 1 cycle.
REQ-021 A byte SHALL be captured at a clock edge iff, at that edge, rd_n_o==0 and rxf_n_i==0.
REQ-022 READ SHALL go to RELEASE at any edge where rxf_n_i==1, enable_i==0, fill >= FIFO_DEPTH-2, or the burst count including this edge's capture reaches MAX_BURST (when MAX_BURST != 0).
REQ-023 A byte present at the exit edge SHALL still be captured; no capture SHALL occur after exit, and FIFO overflow SHALL be impossible.
REQ-024 RELEASE SHALL last 1 cycle, then go to GAP if the exit cause was the burst limit and GAP_CYCLES > 0; otherwise to IDLE.
REQ-025 GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE.
REQ-026 The burst counter SHALL clear on entry to TURN.
REQ-027 The packer SHALL place captured bytes at byte lanes 0..BYTES_PER_WORD-1 in order.
REQ-028 A completed word SHALL be pushed to the FIFO on the edge its last byte is captured, with keep all ones.
REQ-029 On flush_i with lanes filled k > 0, the packer SHALL push a word with the filled lanes, zero in unfilled lanes, and keep = (1<<k)-1; flush_i with k == 0 SHALL do nothing.
REQ-030 When flush_i coincides with a capture, the byte SHALL be packed first; if this completes the word, a single full word SHALL be pushed; otherwise the partial word including the new byte SHALL be pushed.
REQ-031 The FIFO SHALL be first-word fall-through, with m_valid_o = not empty.
REQ-032 A word SHALL be popped on m_valid_o && m_ready_i, and simultaneous push and pop SHALL leave fill unchanged.
REQ-033 Output data SHALL be held stable while m_valid_o && !m_ready_i.
REQ-034 rx_count_o SHALL increment by 1 per captured byte and wrap from 0xFFFFFFFF to 0.

Reset
REQ-035 On rst_i assertion, independent of clock, the block SHALL go to IDLE with rd_n_o=1, oe_n_o=1, m_valid_o=0, busy_o=0, m_data_o=0, m_keep_o=0, rx_count_o=0, the FIFO empty, and the packer and burst/gap counters cleared.
REQ-036 Reset mid-burst SHALL discard all buffered and partial data.
REQ-037 After rst_i deassertion the first possible TURN SHALL be 1 cycle later.

Verification
REQ-038 Defaults, m_ready_i=1, rxf_n_i low for 5 bytes 0x11..0x55: oe_n_o falls 1 cycle before rd_n_o, 5 words out in order, rx_count_o=5, then RELEASE -> IDLE.
REQ-039 BYTES_PER_WORD=4, 6 bytes 0x01..0x06 then flush_i: words 0x04030201 keep 0xF and 0x00000605 keep 0x3.
REQ-040 FIFO_DEPTH=8, m_ready_i=0, continuous data: RD# rises with fill <= 8, no byte lost; on m_ready_i=1 all words drain and reading resumes.
REQ-041 MAX_BURST=4, GAP_CYCLES=2, continuous data: exactly 4 bytes per READ, then 1 RELEASE cycle + 2 GAP cycles with oe_n_o=1, then a new burst.
REQ-042 rxf_n_i high for one cycle mid-burst: that edge has no capture, READ -> RELEASE -> IDLE -> TURN, no duplicate or lost byte.
REQ-043 rst_i pulse asynchronous to clk_i mid-READ: rd_n_o/oe_n_o go to 1 immediately, m_valid_o=0, rx_count_o=0.
